// File: rtl/coeff_bank_manager_pkg.sv
// Shared constants, FSM state type and helpers for the equalizer coefficient bank manager.
package eq_coeff_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoading = 2'd1,
    StPending = 2'd2
  } state_e;

  // Write counter increments until it reaches DEPTH, then holds.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(DEPTH)) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/coeff_bank_manager_if.sv
// Coefficient-write bus from input_register into the coefficient bank manager.
interface coeff_bank_manager_if;
  import eq_coeff_pkg::*;

  logic                     write_enable;
  logic                     write_done;
  logic [ADDR_W-1:0]        write_address;
  logic signed [DATA_W-1:0] coeffs_in;

  modport master (
    output write_enable,
    output write_done,
    output write_address,
    output coeffs_in
  );

  modport slave (
    input write_enable,
    input write_done,
    input write_address,
    input coeffs_in
  );

endinterface

// File: rtl/coeff_bank_manager_ram_bank.sv
// One coefficient bank: DEPTH x DATA_W storage, single write port, registered read port.
module coeff_ram_bank
  import eq_coeff_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_enable,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (clk_enable && i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (clk_enable) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/coeff_bank_manager.sv
// Double-buffered biquad coefficient store: host loads the shadow bank, swap commits on a sample strobe.
module coeff_bank_manager
  import eq_coeff_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  coeff_bank_manager_if.slave      i_wr_bus,
  input  logic                     i_sample_strobe,
  input  logic [ADDR_W-1:0]        i_rd_address,
  output logic signed [DATA_W-1:0] o_rd_coeff,
  output logic                     o_bank_sel,
  output logic                     o_swap_pending,
  output logic [ADDR_W:0]          o_write_count,
  output logic                     o_load_error
);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_bank_sel;
  logic              r_swap_pending;
  logic              r_load_error;
  logic              r_rd_sel;
  logic [ADDR_W:0]   r_write_count;

  logic              w_accept;
  logic              w_drop;
  logic              w_swap;
  logic              w_we0;
  logic              w_we1;
  logic [DATA_W-1:0] w_rdata0;
  logic [DATA_W-1:0] w_rdata1;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      StIdle: begin
        // A lone write_done with nothing loaded is ignored.
        if (i_wr_bus.write_enable) begin
          w_accept     = 1'b1;
          w_state_next = i_wr_bus.write_done ? StPending : StLoading;
        end
      end
      StLoading: begin
        w_accept = i_wr_bus.write_enable;
        if (i_wr_bus.write_done) begin
          w_state_next = StPending;
        end
      end
      StPending: begin
        w_drop = i_wr_bus.write_enable;
        // Gating on the registered flag keeps a same-cycle done+strobe from swapping.
        if (i_sample_strobe && r_swap_pending) begin
          w_swap       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= StIdle;
      r_bank_sel     <= 1'b0;
      r_swap_pending <= 1'b0;
      r_load_error   <= 1'b0;
      r_rd_sel       <= 1'b0;
      r_write_count  <= '0;
    end else if (clk_enable) begin
      r_state        <= w_state_next;
      r_swap_pending <= (w_state_next == StPending);
      // Read mux follows the bank that was active when the address was sampled.
      r_rd_sel       <= r_bank_sel;
      if (w_swap) begin
        r_bank_sel    <= ~r_bank_sel;
        r_write_count <= '0;
      end else if (w_accept) begin
        r_write_count <= sat_inc(r_write_count);
      end
      if (w_drop) begin
        r_load_error <= 1'b1;
      end
    end
  end

  // Writes always target the shadow bank, reads the active one.
  assign w_we0 = w_accept & r_bank_sel;
  assign w_we1 = w_accept & ~r_bank_sel;

  coeff_ram_bank u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .i_we       (w_we0),
    .i_waddr    (i_wr_bus.write_address),
    .i_wdata    (i_wr_bus.coeffs_in),
    .i_raddr    (i_rd_address),
    .o_rdata    (w_rdata0)
  );

  coeff_ram_bank u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .i_we       (w_we1),
    .i_waddr    (i_wr_bus.write_address),
    .i_wdata    (i_wr_bus.coeffs_in),
    .i_raddr    (i_rd_address),
    .o_rdata    (w_rdata1)
  );

  assign o_rd_coeff     = r_rd_sel ? w_rdata1 : w_rdata0;
  assign o_bank_sel     = r_bank_sel;
  assign o_swap_pending = r_swap_pending;
  assign o_write_count  = r_write_count;
  assign o_load_error   = r_load_error;

endmodule
